// File: rtl/bf_concat_ser.sv
// ChaCha20 keystream generator: RFC 8439 block function, one double-half round per cycle,
// serialised little-endian into a concatenated byte buffer.
module bf_concat_ser #(
    parameter int DATA_SIZE    = 8,
    parameter int NUM_MATRICES = 1,
    parameter int NO_REG       = 64 * NUM_MATRICES
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [0:7][31:0]                    Key,
    input  logic [2:0][31:0]                    Nonce,
    input  logic [3:0][31:0]                    Constant,
    output logic [0:NO_REG-1][DATA_SIZE-1:0]    concatout,
    output logic                                full,
    output logic                                blockready
);

    localparam int MW = (NUM_MATRICES > 1) ? $clog2(NUM_MATRICES) : 1;
    localparam int IW = $clog2(NO_REG);

    typedef enum logic [2:0] {
        LOAD,
        ROUND,
        ADD,
        SER,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [4:0]        rnd;
    logic [5:0]        k;
    logic [MW-1:0]     m;
    logic [31:0]       ctr;
    logic [15:0][31:0] init;
    logic [15:0][31:0] wk;
    logic [15:0][31:0] outw;
    logic [15:0][31:0] st0;
    logic [15:0][31:0] rnd_wk;
    logic [IW-1:0]     idx;
    logic              last_m;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(
        input logic [31:0] a_i,
        input logic [31:0] b_i,
        input logic [31:0] c_i,
        input logic [31:0] d_i
    );
        logic [31:0] a, b, c, d;
        a = a_i;
        b = b_i;
        c = c_i;
        d = d_i;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    always_comb begin
        st0 = '0;
        for (int i = 0; i < 4; i++) begin
            st0[i]     = Constant[i];
            st0[4 + i] = Key[i];
            st0[8 + i] = Key[4 + i];
        end
        st0[12] = ctr;
        for (int j = 0; j < 3; j++) begin
            st0[13 + j] = Nonce[j];
        end
    end

    // Even round index: column round; odd: diagonal round.
    always_comb begin
        rnd_wk = wk;
        for (int i = 0; i < 4; i++) begin
            if (!rnd[0]) begin
                {rnd_wk[i], rnd_wk[4 + i], rnd_wk[8 + i], rnd_wk[12 + i]} =
                    qr(wk[i], wk[4 + i], wk[8 + i], wk[12 + i]);
            end else begin
                {rnd_wk[i], rnd_wk[4 + ((i + 1) % 4)],
                 rnd_wk[8 + ((i + 2) % 4)], rnd_wk[12 + ((i + 3) % 4)]} =
                    qr(wk[i], wk[4 + ((i + 1) % 4)],
                       wk[8 + ((i + 2) % 4)], wk[12 + ((i + 3) % 4)]);
            end
        end
    end

    assign last_m = (m == MW'(NUM_MATRICES - 1));
    assign idx    = IW'({m, k});

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            LOAD:    state_nxt = ROUND;
            ROUND:   if (rnd == 5'd19) state_nxt = ADD;
            ADD:     state_nxt = SER;
            SER:     if (k == 6'd63) state_nxt = last_m ? DONE : LOAD;
            DONE:    state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rnd        <= '0;
            k          <= '0;
            m          <= '0;
            ctr        <= 32'd1;
            init       <= '0;
            wk         <= '0;
            outw       <= '0;
            concatout  <= '0;
            full       <= 1'b0;
            blockready <= 1'b0;
        end else begin
            full       <= 1'b0;
            blockready <= 1'b0;
            unique case (state)
                LOAD: begin
                    init <= st0;
                    wk   <= st0;
                    rnd  <= '0;
                end
                ROUND: begin
                    wk  <= rnd_wk;
                    rnd <= rnd + 5'd1;
                end
                ADD: begin
                    for (int i = 0; i < 16; i++) begin
                        outw[i] <= wk[i] + init[i];
                    end
                    ctr        <= ctr + 32'd1;
                    blockready <= 1'b1;
                end
                SER: begin
                    concatout[idx] <= DATA_SIZE'(outw[k[5:2]][{k[1:0], 3'b000} +: 8]);
                    k <= k + 6'd1;
                    if (k == 6'd63) begin
                        if (last_m) begin
                            full <= 1'b1;
                        end else begin
                            m <= m + MW'(1);
                        end
                    end
                end
                DONE: begin
                    m <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bf_concat_ser.sv
// Self-checking bench for bf_concat_ser: RFC vectors, pattern sweep, random blocks,
// pulse timing, mid-block reset and mid-block key changes against a reference model.
module tb_bf_concat_ser;

    logic              clk = 1'b0;
    logic              rst;
    logic [0:7][31:0]  key;
    logic [2:0][31:0]  nonce;
    logic [3:0][31:0]  cnst;
    logic [0:63][7:0]  cout;
    logic              full;
    logic              br;

    int                total = 0;
    int                bad   = 0;
    logic [31:0]       exp_ctr;

    always #5 clk = ~clk;

    bf_concat_ser dut (
        .clk        (clk),
        .rst        (rst),
        .Key        (key),
        .Nonce      (nonce),
        .Constant   (cnst),
        .concatout  (cout),
        .full       (full),
        .blockready (br)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // RFC 8439 block function: 10 double rounds over the 8 quarter-round index sets
    function automatic void model(
        input  logic [0:7][31:0] kk,
        input  logic [2:0][31:0] nn,
        input  logic [3:0][31:0] cc,
        input  logic [31:0]      cnt,
        output logic [31:0]      o [16]
    );
        logic [31:0] s [16];
        logic [31:0] x [16];
        int t [8][4];
        int a, b, c, d;
        t = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
              '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
        for (int i = 0; i < 4; i++) begin
            s[i]     = cc[i];
            s[4 + i] = kk[i];
            s[8 + i] = kk[4 + i];
        end
        s[12] = cnt;
        for (int j = 0; j < 3; j++) s[13 + j] = nn[j];
        x = s;
        for (int r = 0; r < 10; r++) begin
            for (int q = 0; q < 8; q++) begin
                a = t[q][0]; b = t[q][1]; c = t[q][2]; d = t[q][3];
                x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
                x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
                x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
                x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
            end
        end
        for (int i = 0; i < 16; i++) o[i] = x[i] + s[i];
    endfunction

    function automatic logic [31:0] word_at(input int w);
        return {cout[4*w+3], cout[4*w+2], cout[4*w+1], cout[4*w]};
    endfunction

    function automatic logic [63:0] first8();
        return {cout[0], cout[1], cout[2], cout[3], cout[4], cout[5], cout[6], cout[7]};
    endfunction

    task automatic chk_reset(input string tag);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < 64; i++) acc = acc | cout[i];
        chk($sformatf("%s_full", tag), 64'(full), 64'd0);
        chk($sformatf("%s_br", tag), 64'(br), 64'd0);
        chk($sformatf("%s_clr", tag), 64'(acc), 64'd0);
    endtask

    // Called just before the DUT's LOAD; snapshots inputs for the model.
    task automatic run_block(input string tag, input int exp_br, input bit chg);
        logic [31:0] o [16];
        int n;
        bit ov;
        ov = 1'b0;
        model(key, nonce, cnst, exp_ctr, o);
        exp_ctr = exp_ctr + 32'd1;
        n = 0;
        while (!br && n < 200) begin
            @(negedge clk);
            n++;
            if (br && full) ov = 1'b1;
            if (chg && n == 5) begin
                for (int i = 0; i < 8; i++) key[i] = $urandom;
            end
        end
        chk($sformatf("%s_br_lat", tag), 64'(n), 64'(exp_br));
        @(negedge clk);
        chk($sformatf("%s_br_pulse", tag), 64'(br), 64'd0);
        n = 1;
        while (!full && n < 200) begin
            @(negedge clk);
            n++;
            if (br && full) ov = 1'b1;
        end
        chk($sformatf("%s_full_lat", tag), 64'(n), 64'd64);
        chk($sformatf("%s_excl", tag), 64'(ov), 64'd0);
        for (int w = 0; w < 16; w++) begin
            chk($sformatf("%s_w%0d", tag, w), 64'(word_at(w)), 64'(o[w]));
        end
    endtask

    task automatic set_all(input logic [31:0] v);
        for (int i = 0; i < 8; i++) key[i] = v;
        for (int i = 0; i < 3; i++) nonce[i] = v;
        for (int i = 0; i < 4; i++) cnst[i] = v;
    endtask

    task automatic std_const();
        cnst[0] = 32'h61707865;
        cnst[1] = 32'h3320646e;
        cnst[2] = 32'h79622d32;
        cnst[3] = 32'h6b206574;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(negedge clk);
        exp_ctr = 32'd1;
    endtask

    initial begin
        rst = 1'b0;
        exp_ctr = 32'd1;
        std_const();
        for (int i = 0; i < 8; i++) key[i] = 32'h03020100 + 32'(i) * 32'h04040404;
        nonce[0] = 32'h09000000;
        nonce[1] = 32'h4a000000;
        nonce[2] = 32'h00000000;
        repeat (3) @(negedge clk);
        chk_reset("init");

        rst = 1'b1;
        run_block("rfc1", 22, 1'b0);
        chk("rfc_r0w0", 64'(word_at(0)), 64'h e4e7f110);
        chk("rfc_r0w1", 64'(word_at(1)), 64'h 15593bd1);
        chk("rfc_r0w2", 64'(word_at(2)), 64'h 1fdd0f50);
        chk("rfc_r0w3", 64'(word_at(3)), 64'h c47120a3);
        chk("rfc_bytes", first8(), 64'h10f1e7e4d13b5915);
        run_block("rfc2", 23, 1'b0);

        pulse_reset();
        std_const();
        for (int i = 0; i < 8; i++) key[i] = '0;
        for (int i = 0; i < 3; i++) nonce[i] = '0;
        rst = 1'b1;
        run_block("zero", 22, 1'b0);
        chk("zero_bytes", first8(), 64'h9f07e7be5551387a);

        repeat (10) @(negedge clk);
        pulse_reset();
        chk_reset("rst_round");
        rst = 1'b1;
        run_block("after_rr", 22, 1'b0);
        chk("after_rr_bytes", first8(), 64'h9f07e7be5551387a);

        repeat (40) @(negedge clk);
        pulse_reset();
        chk_reset("rst_ser");

        for (int p = 0; p < 16; p++) begin
            set_all(32'h11111111 * 32'(p));
            rst = 1'b1;
            run_block($sformatf("pat%0h", p), (p == 0) ? 22 : 23, 1'b0);
        end

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) nonce[i] = $urandom;
            for (int i = 0; i < 4; i++) cnst[i] = $urandom;
            run_block($sformatf("rnd%0d", r), 23, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
